// File: rtl/cache_pkg.sv
// Cache-subsystem types: arbiter grant states.
package cache_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_D, ARB_I} arb_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM controller status encoding.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache onto the single RAM port; dcache priority with an icache starvation guard.
// Optional ARB_STATS_EN adds completion and starvation-pick counters.
//
// state    | meaning
// ARB_IDLE | no grant held; pick combinationally and drive RAM this cycle
// ARB_D    | dcache granted, held until ACCESS or abort
// ARB_I    | icache granted, held until ACCESS or abort
module cache_mem_arbiter
   import cpu_types_pkg::*;
   import cache_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output word_t     iload,
   output logic      iwait,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output word_t     dload,
   output logic      dwait,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate
`ifdef ARB_STATS_EN
   ,
   output logic [31:0] stat_dgrant,
   output logic [31:0] stat_igrant,
   output logic [31:0] stat_starve
`endif
);

   arb_state_t state, next_state;
   logic [7:0] starve_cnt;
   logic       d_req, starve_hit, access;
   logic       sel_d, sel_i;

   assign d_req      = dREN | dWEN;
   assign starve_hit = (starve_cnt >= 8'(STARVE_LIMIT));
   assign access     = (ramstate == ACCESS);
   assign iload      = ramload;
   assign dload      = ramload;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= ARB_IDLE;
         starve_cnt <= '0;
      end else begin
         state <= next_state;
         if (!iREN)
            starve_cnt <= '0;
         else if (sel_i) begin
            if (access)
               starve_cnt <= '0;
         end else if (!starve_hit)
            starve_cnt <= starve_cnt + 8'd1;
      end
   end

   always_comb begin
      next_state = state;
      sel_d      = 1'b0;
      sel_i      = 1'b0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iwait      = 1'b1;
      dwait      = 1'b1;

      unique case (state)
         ARB_IDLE: begin
            if (iREN && starve_hit) sel_i = 1'b1;
            else if (d_req)         sel_d = 1'b1;
            else if (iREN)          sel_i = 1'b1;
         end
         ARB_D:   sel_d = d_req;
         ARB_I:   sel_i = iREN;
         default: ;
      endcase

      if (sel_d) begin
         ramaddr = daddr;
         if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
         end else begin
            ramREN = 1'b1;
         end
         dwait = !access;
      end else if (sel_i) begin
         ramaddr = iaddr;
         ramREN  = 1'b1;
         iwait   = !access;
      end

      unique case (state)
         ARB_IDLE: begin
            if (!access) begin
               if (sel_d)      next_state = ARB_D;
               else if (sel_i) next_state = ARB_I;
            end
         end
         ARB_D, ARB_I: begin
            // dropping the request before ACCESS abandons the grant
            if (!(sel_d || sel_i) || access) next_state = ARB_IDLE;
         end
         default: next_state = ARB_IDLE;
      endcase

      // outputs follow reset immediately, not at the next edge
      if (!nRST) begin
         ramREN   = 1'b0;
         ramWEN   = 1'b0;
         ramaddr  = '0;
         ramstore = '0;
         iwait    = 1'b1;
         dwait    = 1'b1;
      end
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_dgrant <= '0;
         stat_igrant <= '0;
         stat_starve <= '0;
      end else begin
         if (sel_d && access) stat_dgrant <= stat_dgrant + 32'd1;
         if (sel_i && access) stat_igrant <= stat_igrant + 32'd1;
         if (state == ARB_IDLE && iREN && starve_hit) stat_starve <= stat_starve + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: idle-pick vector table plus multi-cycle sequences.
module tb_cache_mem_arbiter;
   import cpu_types_pkg::*;
   import cache_pkg::*;

   logic      CLK = 1'b0;
   logic      nRST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   word_t     iload, dload, ramaddr, ramstore;
   logic      iwait, dwait, ramREN, ramWEN;
   ramstate_t ramstate;

   int n_tests = 0;
   int n_fail  = 0;

   cache_mem_arbiter #(.STARVE_LIMIT(8)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic      iren, dren, dwen;
      word_t     ia, da, ds;
      ramstate_t rs;
      logic      e_ren, e_wen;
      word_t     e_addr, e_store;
      logic      e_iw, e_dw;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic dr, input logic dw, input word_t ia,
                        input word_t da, input word_t ds, input ramstate_t rs);
      iREN = ir; dREN = dr; dWEN = dw;
      iaddr = ia; daddr = da; dstore = ds; ramstate = rs;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, FREE);
      step();
   endtask

   int first_i;

   initial begin
      vt[0] = '{1'b0,1'b0,1'b0, 32'h40, 32'h100, 32'h5,        FREE,   1'b0,1'b0, 32'h0,   32'h0,        1'b1,1'b1};
      vt[1] = '{1'b0,1'b1,1'b0, 32'h40, 32'h100, 32'h5,        ACCESS, 1'b1,1'b0, 32'h100, 32'h0,        1'b1,1'b0};
      vt[2] = '{1'b0,1'b0,1'b1, 32'h40, 32'h200, 32'hDEADBEEF, ACCESS, 1'b0,1'b1, 32'h200, 32'hDEADBEEF, 1'b1,1'b0};
      vt[3] = '{1'b0,1'b1,1'b1, 32'h40, 32'h204, 32'h12345678, ACCESS, 1'b0,1'b1, 32'h204, 32'h12345678, 1'b1,1'b0};
      vt[4] = '{1'b1,1'b0,1'b0, 32'h44, 32'h100, 32'h5,        ACCESS, 1'b1,1'b0, 32'h44,  32'h0,        1'b0,1'b1};
      vt[5] = '{1'b1,1'b1,1'b0, 32'h44, 32'h108, 32'h5,        ACCESS, 1'b1,1'b0, 32'h108, 32'h0,        1'b1,1'b0};
      vt[6] = '{1'b1,1'b0,1'b1, 32'h48, 32'h10C, 32'hCAFEF00D, BUSY,   1'b0,1'b1, 32'h10C, 32'hCAFEF00D, 1'b1,1'b1};
      vt[7] = '{1'b1,1'b0,1'b0, 32'h4C, 32'h100, 32'h5,        ERROR,  1'b1,1'b0, 32'h4C,  32'h0,        1'b1,1'b1};
      vt[8] = '{1'b0,1'b0,1'b0, 32'h40, 32'h100, 32'h5,        ACCESS, 1'b0,1'b0, 32'h0,   32'h0,        1'b1,1'b1};

      // reset with both requesters active
      nRST = 1'b0;
      ramload = 32'h0;
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'hAA0, 32'h0, FREE);
      #2;
      chk("rst.ramREN", 32'(ramREN), 32'd0);
      chk("rst.ramWEN", 32'(ramWEN), 32'd0);
      chk("rst.iwait",  32'(iwait),  32'd1);
      chk("rst.dwait",  32'(dwait),  32'd1);
      chk("rst.ramaddr", ramaddr, 32'h0);
      step();
      step();
      nRST = 1'b1;
      @(negedge CLK);
      chk("rst.first_addr", ramaddr, 32'hAA0);
      chk("rst.first_ren", 32'(ramREN), 32'd1);
      step();
      idle_cycle();

      for (int i = 0; i < 9; i++) begin
         idle_cycle();
         drive(vt[i].iren, vt[i].dren, vt[i].dwen, vt[i].ia, vt[i].da, vt[i].ds, vt[i].rs);
         ramload = 32'hA5A5_0000 + 32'(i);
         @(negedge CLK);
         chk($sformatf("vec%0d.ramREN", i),   32'(ramREN), 32'(vt[i].e_ren));
         chk($sformatf("vec%0d.ramWEN", i),   32'(ramWEN), 32'(vt[i].e_wen));
         chk($sformatf("vec%0d.ramaddr", i),  ramaddr,     vt[i].e_addr);
         chk($sformatf("vec%0d.ramstore", i), ramstore,    vt[i].e_store);
         chk($sformatf("vec%0d.iwait", i),    32'(iwait),  32'(vt[i].e_iw));
         chk($sformatf("vec%0d.dwait", i),    32'(dwait),  32'(vt[i].e_dw));
         chk($sformatf("vec%0d.iload", i),    iload,       32'hA5A5_0000 + 32'(i));
         chk($sformatf("vec%0d.dload", i),    dload,       32'hA5A5_0000 + 32'(i));
         step();
      end
      idle_cycle();

      // zero-latency RAM: completes every cycle without leaving idle
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, ACCESS);
         @(negedge CLK);
         chk($sformatf("zl%0d.ramREN", c),  32'(ramREN), 32'd1);
         chk($sformatf("zl%0d.ramaddr", c), ramaddr, 32'h100);
         chk($sformatf("zl%0d.dwait", c),   32'(dwait), 32'd0);
         chk($sformatf("zl%0d.state", c),   32'(dut.state), 32'(ARB_IDLE));
         step();
      end
      idle_cycle();

      // two-cycle RAM, both sides requesting: dcache write first, then icache
      drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h400, 32'hDEADBEEF, BUSY);
      @(negedge CLK);
      chk("t3c0.ramWEN",   32'(ramWEN), 32'd1);
      chk("t3c0.ramREN",   32'(ramREN), 32'd0);
      chk("t3c0.ramstore", ramstore, 32'hDEADBEEF);
      chk("t3c0.ramaddr",  ramaddr, 32'h400);
      chk("t3c0.dwait",    32'(dwait), 32'd1);
      step();
      ramstate = ACCESS;
      @(negedge CLK);
      chk("t3c1.dwait", 32'(dwait), 32'd0);
      chk("t3c1.iwait", 32'(iwait), 32'd1);
      step();
      dWEN = 1'b0;
      ramstate = BUSY;
      @(negedge CLK);
      chk("t3c2.ramREN",  32'(ramREN), 32'd1);
      chk("t3c2.ramWEN",  32'(ramWEN), 32'd0);
      chk("t3c2.ramaddr", ramaddr, 32'h300);
      chk("t3c2.iwait",   32'(iwait), 32'd1);
      step();
      ramstate = ACCESS;
      @(negedge CLK);
      chk("t3c3.iwait", 32'(iwait), 32'd0);
      chk("t3c3.dwait", 32'(dwait), 32'd1);
      step();
      idle_cycle();

      // starvation: back-to-back dcache reads must yield to icache by cycle 8
      first_i = 99;
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h500, 32'h600, 32'h0, (c % 2 == 1) ? ACCESS : BUSY);
         @(negedge CLK);
         if (first_i == 99 && ramREN && ramaddr == 32'h500) first_i = c;
         if (c == 9) chk("starve.iwait", 32'(iwait), 32'd0);
         step();
      end
      chk("starve.first_i", 32'(first_i), 32'd8);
      drive(1'b1, 1'b1, 1'b0, 32'h500, 32'h600, 32'h0, BUSY);
      @(negedge CLK);
      chk("starve.cnt_clr", 32'(dut.starve_cnt), 32'd0);
      chk("starve.back_to_d", ramaddr, 32'h600);
      step();
      idle_cycle();

      // abort: icache drops its request while RAM is busy
      drive(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 32'h0, BUSY);
      @(negedge CLK);
      chk("abort.c0_ren",  32'(ramREN), 32'd1);
      chk("abort.c0_addr", ramaddr, 32'h700);
      step();
      iREN = 1'b0;
      @(negedge CLK);
      chk("abort.c1_ren",   32'(ramREN), 32'd0);
      chk("abort.c1_iwait", 32'(iwait), 32'd1);
      step();
      ramstate = ACCESS;
      @(negedge CLK);
      chk("abort.c2_state", 32'(dut.state), 32'(ARB_IDLE));
      chk("abort.c2_iwait", 32'(iwait), 32'd1);
      step();
      idle_cycle();

      // ERROR is never acknowledged; reset mid-transaction clears everything at once
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h800, 32'h0, BUSY);
      step();
      ramstate = ERROR;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         chk($sformatf("err%0d.dwait", c),  32'(dwait), 32'd1);
         chk($sformatf("err%0d.ramREN", c), 32'(ramREN), 32'd1);
         chk($sformatf("err%0d.state", c),  32'(dut.state), 32'(ARB_D));
         step();
      end
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      chk("midrst.ramREN",  32'(ramREN), 32'd0);
      chk("midrst.ramaddr", ramaddr, 32'h0);
      chk("midrst.dwait",   32'(dwait), 32'd1);
      chk("midrst.iwait",   32'(iwait), 32'd1);
      chk("midrst.state",   32'(dut.state), 32'(ARB_IDLE));
      idle_cycle();
      nRST = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
